conv_puncturer: RTL and testbench

- Puncturing stage directly downstream of the 802.11a rate-1/2 convolutional encoder.
- Consumes the encoder's serial coded stream, ordered A0 B0 A1 B1 ... (A = g0 output, B = g1 output).
- Deletes ("steals") bits per the 802.11a pattern to produce rate 1/2, 2/3 or 3/4.
- Feeds the interleaver through a registered valid/ready output stage.

---
 rtl/conv_puncturer_if.sv | 28 ++
 rtl/conv_puncturer.sv | 96 +++++++++
 tb/tb_conv_puncturer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/conv_puncturer_if.sv
// Bus between the convolutional encoder, the puncturer and the interleaver:
// serial coded input with frame sync and rate select, punctured output, and
// the count of output bits in the current frame.
interface conv_puncturer_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   in_bit;
  logic                   in_valid;
  logic                   in_ready;
  logic                   sync;
  logic [1:0]             rate;
  logic                   out_bit;
  logic                   out_valid;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] bit_count;

  // Environment side: drives the encoder stream and the downstream ready.
  modport master (
    output in_bit, in_valid, sync, rate, out_ready,
    input  in_ready, out_bit, out_valid, bit_count
  );

  // Puncturer side.
  modport slave (
    input  in_bit, in_valid, sync, rate, out_ready,
    output in_ready, out_bit, out_valid, bit_count
  );
endinterface

// File: rtl/conv_puncturer.sv
// 802.11a puncturer: steals bits from the rate-1/2 coded stream A0 B0 A1 B1 ...
// to give rate 1/2, 2/3 or 3/4, with a single registered output stage.
module conv_puncturer #(
  parameter int COUNT_WIDTH = 16
) (
  input logic             i_clock,
  input logic             i_reset_n,
  conv_puncturer_if.slave bus
);

  localparam logic [1:0] RATE_12 = 2'b00;
  localparam logic [1:0] RATE_23 = 2'b01;
  localparam logic [1:0] RATE_34 = 2'b10;

  logic [1:0]             r_rate;
  logic [2:0]             r_phase;
  logic                   r_out_bit;
  logic                   r_out_valid;
  logic [COUNT_WIDTH-1:0] r_bit_count;

  logic                   w_accept;
  logic                   w_xfer;
  logic [1:0]             w_rate_sel;
  logic [1:0]             w_rate_eff;
  logic [2:0]             w_phase;
  logic [2:0]             w_phase_next;
  logic                   w_keep;
  logic [COUNT_WIDTH-1:0] w_count_inc;

  // The output register may take a new bit whenever it is empty or being drained.
  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_xfer        = r_out_valid && bus.out_ready;
  assign bus.out_bit   = r_out_bit;
  assign bus.out_valid = r_out_valid;
  assign bus.bit_count = r_bit_count;
  assign w_count_inc   = r_bit_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Keep/steal decision; a sync bit is judged as phase 0 of the new rate.
  always_comb begin
    w_rate_sel   = bus.sync ? bus.rate : r_rate;
    w_rate_eff   = (w_rate_sel == 2'b11) ? RATE_12 : w_rate_sel;
    w_phase      = bus.sync ? 3'd0 : r_phase;
    w_keep       = 1'b1;
    w_phase_next = w_phase + 3'd1;
    case (w_rate_eff)
      RATE_23: begin
        w_keep = (w_phase != 3'd3);
        if (w_phase >= 3'd3) w_phase_next = 3'd0;
      end
      RATE_34: begin
        w_keep = (w_phase != 3'd3) && (w_phase != 3'd4);
        if (w_phase >= 3'd5) w_phase_next = 3'd0;
      end
      default: begin
        if (w_phase >= 3'd1) w_phase_next = 3'd0;
      end
    endcase
  end

  // Rate and phase tracking; rate only changes on an accepted sync.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rate  <= RATE_12;
      r_phase <= 3'd0;
    end else if (w_accept) begin
      r_phase <= w_phase_next;
      if (bus.sync) r_rate <= w_rate_eff;
    end
  end

  // Output stage: load kept bits, empty on a transfer with nothing new behind it.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept && w_keep) begin
      r_out_bit   <= bus.in_bit;
      r_out_valid <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Frame bit counter; a transfer coinciding with sync belongs to the old frame.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bit_count <= '0;
    end else if (w_accept && bus.sync) begin
      r_bit_count <= '0;
    end else if (w_xfer && !(&r_bit_count)) begin
      r_bit_count <= w_count_inc;
    end
  end

endmodule

// File: tb/tb_conv_puncturer.sv
// Directed bench for conv_puncturer with hand-computed expected output streams.
module tb_conv_puncturer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   stall_seen;
  bit   q[$];

  conv_puncturer_if #(.COUNT_WIDTH(16)) bus();

  conv_puncturer #(.COUNT_WIDTH(16)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every transfer and any offered-but-refused input, away from the edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) q.push_back(bus.out_bit);
    if (rst_n && bus.in_valid && !bus.in_ready) stall_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare the captured output stream with a string of '0'/'1' characters.
  task automatic chk_q(input string tag, input string e);
    chk({tag, "_len"}, q.size(), e.len());
    for (int i = 0; i < e.len() && i < q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {31'd0, q[i]}, {31'd0, e[i] == "1"});
  endtask

  task automatic drive(input logic b, input logic s, input logic [1:0] r);
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    bus.sync     = s;
    bus.rate     = r;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sync     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [11:0] v34;
    logic [7:0]  v23;
    total = 0;
    bad = 0;
    stall_seen = 0;
    rst_n = 1'b0;
    bus.in_bit = 1'b0;
    bus.in_valid = 1'b0;
    bus.sync = 1'b0;
    bus.rate = 2'b00;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_bit", bus.out_bit, 0);
    chk("rst_count", bus.bit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Rate 1/2 passthrough, one cycle latency per bit.
    q.delete();
    drive(1, 1, 2'b00); chk("r12_lat0", {bus.out_valid, bus.out_bit}, 2'b11);
    drive(0, 0, 2'b00); chk("r12_lat1", {bus.out_valid, bus.out_bit}, 2'b10);
    drive(1, 0, 2'b00); chk("r12_lat2", {bus.out_valid, bus.out_bit}, 2'b11);
    drive(1, 0, 2'b00); chk("r12_lat3", {bus.out_valid, bus.out_bit}, 2'b11);
    idle(2);
    chk_q("r12", "1011");
    chk("r12_count", bus.bit_count, 4);
    chk("r12_drain", bus.out_valid, 0);

    // Rate 3/4: 12 coded bits in, 8 out, no input stall.
    q.delete();
    stall_seen = 0;
    v34 = 12'b0111_0100_1101;
    for (int i = 0; i < 12; i++) drive(v34[i], i == 0, 2'b10);
    idle(2);
    chk_q("r34", "10101010");
    chk("r34_count", bus.bit_count, 8);
    chk("r34_no_stall", stall_seen, 0);

    // Rate 2/3: 8 coded bits in, 6 out.
    q.delete();
    v23 = 8'b0110_1011;
    for (int i = 0; i < 8; i++) drive(v23[i], i == 0, 2'b01);
    idle(2);
    chk_q("r23", "110011");
    chk("r23_count", bus.bit_count, 6);

    // Rate input moved without sync: 2/3 pattern continues, count keeps going.
    q.delete();
    drive(1, 0, 2'b00);
    drive(0, 0, 2'b00);
    drive(1, 0, 2'b00);
    drive(1, 0, 2'b00);
    idle(2);
    chk_q("nosync", "101");
    chk("nosync_count", bus.bit_count, 9);

    // Resync mid 3/4 frame to reserved rate; pending bit belongs to old frame.
    q.delete();
    drive(1, 1, 2'b10);
    drive(0, 0, 2'b10);
    drive(1, 0, 2'b10);
    drive(0, 1, 2'b11);
    drive(1, 0, 2'b00);
    drive(1, 0, 2'b00);
    drive(0, 0, 2'b00);
    idle(2);
    chk_q("resync", "1010110");
    chk("resync_count", bus.bit_count, 4);

    // Backpressure for three cycles at rate 1/2.
    q.delete();
    drive(1, 1, 2'b00);
    bus.out_ready = 1'b0;
    bus.in_bit = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", i), bus.in_ready, 0);
      chk($sformatf("bp_hold%0d", i), {bus.out_valid, bus.out_bit}, 2'b11);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drive(1, 0, 2'b00);
    idle(2);
    chk_q("bp", "101");
    chk("bp_count", bus.bit_count, 3);

    // Asynchronous reset mid 3/4 frame with a held output.
    q.delete();
    drive(1, 1, 2'b10);
    drive(0, 0, 2'b10);
    drive(1, 0, 2'b10);
    bus.out_ready = 1'b0;
    chk("pre_rst_held", {bus.out_valid, bus.out_bit}, 2'b11);
    chk("pre_rst_count", bus.bit_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_bit", bus.out_bit, 0);
    chk("arst_count", bus.bit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    drive(1, 0, 2'b10);
    drive(0, 0, 2'b10);
    drive(1, 0, 2'b10);
    drive(1, 0, 2'b10);
    idle(2);
    chk_q("post_rst", "1011");
    chk("post_rst_count", bus.bit_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
